// File: rtl/uart_rx_byte.sv
// uart_rx_byte: UART byte receiver (8 data bits, LSB first, 1 stop bit).
// Synchronises the asynchronous rs232_rx pin and detects the start bit.
// It samples each bit at mid-bit and checks the stop bit.
// One good byte per valid frame is handed to the command decoder on rx_done.
//
// Optional feature macro: PARITY_CHECK_EN
//   Defined:   one parity bit is expected after data bit 7 and checked
//              against PARITY_ODD. A mismatch pulses parity_err instead of
//              rx_done.
//   Undefined: frame = start + 8 data + stop; parity_err is always 0.
//
// Handshake: rx_done, frame_err and parity_err are single-cycle pulses with no
// back-pressure, and at most one of them is high in any cycle. uart_data
// changes only in the rx_done cycle and is held at all other times.
module uart_rx_byte #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rs232_rx,
  output logic [7:0] uart_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       parity_err,
  output logic       rx_busy,
  output logic [2:0] dbg_state
);

  // BAUD_CNT must be at least 4 so that START has a usable half-bit window.
  localparam int BAUD_CNT = CLK_FREQ / BAUD_RATE;
  localparam int HALF     = BAUD_CNT / 2;
  localparam int CW       = $clog2(BAUD_CNT);

  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic          PAR_ODD  = (PARITY_ODD != 0);

`ifdef PARITY_CHECK_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_bit_q, par_bit_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic          fe_q, fe_d;
  logic          pe_q, pe_d;

  logic sync1_q, sync2_q, dly_q;
  logic rx_s;
  logic start_edge;
  logic cnt_last;
  logic par_bad;

  // Two-flop synchroniser plus delay flop.
  // All three are preset high so that reset cannot fake a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      dly_q   <= 1'b1;
    end else begin
      sync1_q <= rs232_rx;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign rx_s       = sync2_q;
  assign start_edge = dly_q & ~sync2_q;
  assign cnt_last   = (cnt_q == CNT_LAST);
  // The data bits and the parity bit together must XOR to PAR_ODD.
  assign par_bad    = ((^shift_q) ^ par_bit_q) != PAR_ODD;

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      data_q    <= data_d;
      done_q    <= done_d;
      fe_q      <= fe_d;
      pe_q      <= pe_d;
    end
  end

  // Next-state logic: the bit-period counter, bit sampling and the result flags.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    data_d    = data_q;
    done_d    = 1'b0;
    fe_d      = 1'b0;
    pe_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        // At half a bit into the start bit, a high line means a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_last) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_s;
          if (bit_q == 3'd7) begin
            state_d = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (cnt_last) begin
          cnt_d     = '0;
          par_bit_d = rx_s;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        // Leave at mid-stop so that a following start bit is not missed.
        if (cnt_last) begin
          cnt_d = '0;
          if (rx_s) begin
            if (PAR_EN && par_bad) begin
              pe_d = 1'b1;
            end else begin
              done_d = 1'b1;
              data_d = shift_q;
            end
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        // Stay here while the line is held low, so no start edge is taken.
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign uart_data  = data_q;
  assign rx_done    = done_q;
  assign frame_err  = fe_q;
  assign parity_err = pe_q;
  assign rx_busy    = (state_q != S_IDLE);
  assign dbg_state  = state_q;

endmodule
